mealy_seq_detector_param: RTL and testbench
===========================================

// Module: mealy_seq_detector_param
// PURPOSE
//   Runtime-programmable serial sequence detector with a Mealy output. Pattern width,
//   active pattern length and overlap/non-overlap mode are configurable. It sits on a
//   1-bit serial data path qualified by din_valid. It also reports a registered match
//   pulse and a saturating match count for status logic.
// PARAMETERS
//   PAT_W        4        max pattern length in bits (>=2)
//   CNT_W        8        width of saturating match counter
//   DEF_PATTERN  4'b1010  pattern loaded at reset (PAT_W bits)
//   DEF_OVERLAP  0        mode at reset: 0 = non-overlapping, 1 = overlapping
// PORTS
//   clk          in   1                 clock, rising edge
//   reset        in   1                 asynchronous, active-low reset
//   din          in   1                 serial data bit
//   din_valid    in   1                 din is sampled only when 1
//   cfg_load     in   1                 capture cfg_* and flush history
//   cfg_pattern  in   PAT_W             pattern; bit [len-1] is the first received bit, bit 0 the last
//   cfg_len      in   clog2(PAT_W+1)    active length; 0 -> 1, >PAT_W -> PAT_W
//   cfg_overlap  in   1                 1 = overlapping detection
//   cnt_clr      in   1                 synchronous clear of match_cnt
//   dout         out  1                 Mealy match, combinational, same cycle as the last bit
//   match_q      out  1                 dout registered (1-cycle latency)
//   match_cnt    out  CNT_W             number of matches, saturating
// BEHAVIOUR
//   Reset (reset=0, async): hist=0, fill=0, pattern=DEF_PATTERN, len=PAT_W,
//     overlap=DEF_OVERLAP, match_q=0, match_cnt=0. dout=0 during reset.
//   State: hist[PAT_W-1:0] shift register; fill = count of valid bits held, saturates at PAT_W.
//   Window w = {hist[PAT_W-2:0], din}. Mask m = low len bits set.
//   dout = din_valid & ~cfg_load & (fill+1 >= len) & ((w & m) == (pattern & m)).
//   On a clock with din_valid=1 and cfg_load=0:
//     hist <= w.
//     If dout=1 and overlap=0: fill <= 0. Matching bits are consumed and not reused.
//     Otherwise: fill <= min(fill+1, PAT_W).
//   On a clock with din_valid=0: hist and fill hold. dout=0.
//   cfg_load=1 takes priority over din_valid. That cycle's din is discarded, dout=0.
//     pattern, len (clamped) and overlap are captured. hist <= 0, fill <= 0.
//     match_cnt is unaffected.
//   match_q <= dout every clock.
//   match_cnt: cnt_clr=1 -> 0, and this wins over a same-cycle match.
//     Otherwise +1 on dout=1. Holds at {CNT_W{1'b1}}; never wraps.
//   len=1: every valid bit equal to pattern[0] matches. Mode has no effect.
//   Reset asserted mid-sequence discards the partial match. The first match after
//     release needs a full len bits.
//   All comparisons and count arithmetic are unsigned. fill is clog2(PAT_W+1) bits.
// TESTING
//   1 Reset defaults (1010, len 4, non-overlap). din=1,0,1,0,1,0,1,0, valid every cycle
//     -> dout=1 on bits 4 and 8 only; match_q follows 1 cycle later; match_cnt=2.
//   2 cfg_load overlap=1, pattern 1010, len 4. Stream 1,0,1,0,1,0 -> dout=1 on bits 4
//     and 6; match_cnt increments by 2.
//   3 cfg_load pattern 4'b0011, len 2 ("11"), non-overlap. Stream 1,1,1,1,1
//     -> dout on bits 2 and 4. Repeat with overlap=1 -> dout on bits 2,3,4,5.
//   4 Gaps: pattern 1010 with din_valid=0 cycles inserted between bits -> same matches
//     as scenario 1; dout=0 on every invalid cycle.
//   5 Boundaries: cfg_load coincident with a matching last bit -> dout=0, no count.
//     cnt_clr with a same-cycle match -> cnt=0. Force 255 matches with CNT_W=8, then
//     one more -> cnt stays 255.
//   6 Pull reset low after bits 1,0,1 of 1010, then release -> next bit 0 gives no
//     match; a full 1,0,1,0 is needed. cfg_len=0 is treated as 1; cfg_len=7 as 4.

Source files
------------

// File: rtl/mealy_seq_detector_param.sv
// Serial sequence detector with a combinational Mealy match, a registered copy of it
// and a saturating match counter. Pattern, length and overlap mode are loadable at runtime.
module mealy_seq_detector_param #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = 4'b1010,
    parameter bit               DEF_OVERLAP = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         dout,
    output logic                         match_q,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int LEN_W = $clog2(PAT_W+1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist_reg, hist_next;
    logic [PAT_W-1:0] pattern_reg, pattern_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] fill_reg, fill_next;
    logic             overlap_reg, overlap_next;
    logic             match_q_reg;
    logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_inc;
    logic             fill_ok;
    logic             pat_eq;
    logic [LEN_W-1:0] len_clamped;

    assign window = {hist_reg[PAT_W-2:0], din};

    // Only the low len bits of the window take part in the comparison.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi = gi + 1) begin : g_mask
            assign mask[gi] = (len_reg > LEN_W'(gi));
        end
    endgenerate

    assign fill_inc = {1'b0, fill_reg} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok  = (fill_inc >= {1'b0, len_reg});
    assign pat_eq   = ((window & mask) == (pattern_reg & mask));

    // Gated by reset so the output is quiet for the whole time reset is held.
    assign dout = reset & din_valid & ~cfg_load & fill_ok & pat_eq;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        pattern_next = pattern_reg;
        len_next     = len_reg;
        overlap_next = overlap_reg;

        if (cfg_load) begin
            pattern_next = cfg_pattern;
            len_next     = len_clamped;
            overlap_next = cfg_overlap;
            hist_next    = '0;
            fill_next    = '0;
        end else if (din_valid) begin
            hist_next = window;
            if (dout && !overlap_reg) begin
                // Non-overlapping: the matched bits may not seed the next match.
                fill_next = '0;
            end else if (fill_reg != LEN_MAX) begin
                fill_next = fill_inc[LEN_W-1:0];
            end
        end
    end

    always_comb begin
        match_cnt_next = match_cnt_reg;
        if (cnt_clr) begin
            match_cnt_next = '0;
        end else if (dout && (match_cnt_reg != {CNT_W{1'b1}})) begin
            match_cnt_next = match_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_reg      <= '0;
            fill_reg      <= '0;
            pattern_reg   <= DEF_PATTERN;
            len_reg       <= LEN_MAX;
            overlap_reg   <= DEF_OVERLAP;
            match_q_reg   <= 1'b0;
            match_cnt_reg <= '0;
        end else begin
            hist_reg      <= hist_next;
            fill_reg      <= fill_next;
            pattern_reg   <= pattern_next;
            len_reg       <= len_next;
            overlap_reg   <= overlap_next;
            match_q_reg   <= dout;
            match_cnt_reg <= match_cnt_next;
        end
    end

    assign match_q   = match_q_reg;
    assign match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_mealy_seq_detector_param.sv
// Scoreboard bench for mealy_seq_detector_param: expected dout values come from the
// hand-derived scenario tables; match_q and match_cnt expectations follow from them.
module tb_mealy_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W+1);

    logic             clk = 1'b0;
    logic             reset;
    logic             din;
    logic             din_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             dout;
    logic             match_q;
    logic [CNT_W-1:0] match_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;
    bit exp_q[$];

    mealy_seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .DEF_PATTERN(4'b1010),
        .DEF_OVERLAP(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr),
        .dout(dout),
        .match_q(match_q),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One transaction: drive on the falling edge, check dout mid-cycle, then check
    // the registered outputs just after the rising edge.
    task automatic step(input logic d, input logic v, input logic ld, input logic clr, input bit e);
        bit e_pop;
        @(negedge clk);
        din       = d;
        din_valid = v;
        cfg_load  = ld;
        cnt_clr   = clr;
        exp_q.push_back(e);
        #2;
        e_pop = exp_q.pop_front();
        check_eq("dout", 32'(dout), 32'(e_pop));
        if (clr) begin
            exp_cnt = 0;
        end else if (e_pop && exp_cnt != 255) begin
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        check_eq("match_q", 32'(match_q), 32'(e_pop));
        check_eq("match_cnt", 32'(match_cnt), 32'(exp_cnt));
        $display("[TB] t=%0t din=%b v=%b ld=%b clr=%b dout_exp=%b q=%b cnt=%0d",
                 $time, d, v, ld, clr, e_pop, match_q, match_cnt);
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        din         = 1'b1;
        din_valid   = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_match_q", 32'(match_q), 32'd0);
        check_eq("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Defaults, non-overlapping 1010
        for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, (i == 3) || (i == 7));
        check_eq("s1_cnt", 32'(match_cnt), 32'd2);

        // Overlapping 1010
        load_cfg(4'b1010, 3'd4, 1'b1);
        for (int i = 0; i < 6; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, (i == 3) || (i == 5));
        check_eq("s2_cnt", 32'(match_cnt), 32'd4);

        // "11" non-overlap then overlap
        load_cfg(4'b0011, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i == 1) || (i == 3));
        load_cfg(4'b0011, 3'd2, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, i >= 1);

        // Gaps between valid bits; invalid cycles carry the opposite bit value
        load_cfg(4'b1010, 3'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 0, 1'b1, 1'b0, 1'b0, (i == 3) || (i == 7));
            step(i % 2 != 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // cfg_load on the matching last bit suppresses the match and flushes history
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cfg_pattern = 4'b1010; cfg_len = 3'd4; cfg_overlap = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, i == 3);

        // Saturation at 255, then clear coincident with a match
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load_cfg(4'b0001, 3'd1, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("sat_cnt", 32'(match_cnt), 32'd255);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("clr_cnt", 32'(match_cnt), 32'd0);

        // Reset mid-sequence: partial 1,0,1 is discarded
        load_cfg(4'b1010, 3'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; din = 1'b0; din_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
        #2;
        check_eq("midrst_dout", 32'(dout), 32'd0);
        check_eq("midrst_cnt", 32'(match_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, i == 3);

        // Length clamping: 0 acts as 1, 7 acts as 4
        load_cfg(4'b1110, 3'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        load_cfg(4'b1010, 3'd7, 1'b1);
        for (int i = 0; i < 6; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, (i == 3) || (i == 5));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
